// File: rtl/matrix_cfg_loader.sv
// Serial loader for the 18-word switch-matrix configuration. It shifts in 108 data
// bits plus an even-parity bit, validates every word, then commits or rejects the load.
//
// state | meaning
// IDLE  | waiting for cfg_start; active configuration held
// SHIFT | accepting serial bits (108 data + 1 parity)
// CHECK | one-cycle validation; commit (cfg_done) or reject (cfg_err)
module matrix_cfg_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic         cfg_din,
  input  logic         cfg_din_valid,
  output logic         cfg_ready,
  output logic [107:0] cfg_words,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic         cfg_busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [107:0]   shadow_q, shadow_d;
  logic [107:0]   words_q, words_d;
  logic           par_q, par_d;
  logic           words_ok;
  logic           check_ok;
  logic [2:0]     side;
  logic [2:0]     idx;

  // Side 0 leaves the output Hi-Z, so its index field is don't-care.
  always_comb begin
    words_ok = 1'b1;
    side     = 3'd0;
    idx      = 3'd0;
    for (int k = 0; k < 18; k++) begin
      side = shadow_q[6*k +: 3];
      idx  = shadow_q[6*k+3 +: 3];
      case (side)
        3'd0: ;
        3'd1, 3'd3: if (idx > 3'd4) words_ok = 1'b0;
        3'd2, 3'd4: if (idx > 3'd3) words_ok = 1'b0;
        default: words_ok = 1'b0;
      endcase
    end
  end

  assign check_ok = words_ok && !par_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    words_d  = words_q;
    par_d    = par_q;
    cfg_done = 1'b0;
    cfg_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d  = SHIFT;
          cnt_d    = 7'd0;
          shadow_d = '0;
          par_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cfg_start) begin
          cnt_d    = 7'd0;
          shadow_d = '0;
          par_d    = 1'b0;
        end else if (cfg_din_valid) begin
          par_d = par_q ^ cfg_din;
          // Count 108 is the parity bit: it only feeds the parity, never the shadow.
          if (cnt_q == 7'd108) begin
            state_d = CHECK;
          end else begin
            shadow_d = {shadow_q[106:0], cfg_din};
            cnt_d    = cnt_q + 7'd1;
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (check_ok) begin
          words_d  = shadow_q;
          cfg_done = 1'b1;
        end else begin
          cfg_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      shadow_q <= '0;
      words_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      words_q  <= words_d;
      par_q    <= par_d;
    end
  end

  assign cfg_ready = (state_q == SHIFT);
  assign cfg_busy  = (state_q != IDLE);
  assign cfg_words = words_q;

endmodule
